// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error codes, default sync bytes.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        H1,
        LEN,
        PAY,
        CHK
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_PAR  = 2'd2;
    localparam logic [1:0] ERR_LEN  = 2'd3;

    localparam logic [7:0] DEFAULT_HEAD0 = 8'h55;
    localparam logic [7:0] DEFAULT_HEAD1 = 8'hAA;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-wide AXI-Stream bundle; master drives data/valid/last/user, slave drives ready.
interface uart_frame_parser_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; a drain and a new load may share a cycle.
module axis_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_last,
    input  logic       load_user,
    input  logic       tready,
    output logic [7:0] tdata,
    output logic       tvalid,
    output logic       tlast,
    output logic       tuser,
    output logic       free
);

    logic [7:0] data_reg;
    logic       valid_reg;
    logic       last_reg;
    logic       user_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            user_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
            last_reg  <= load_last;
            user_reg  <= load_user;
        end else if (tready) begin
            valid_reg <= 1'b0;
        end
    end

    // Free means a load this cycle cannot overwrite an un-accepted byte.
    assign free   = !valid_reg || tready;
    assign tdata  = data_reg;
    assign tvalid = valid_reg;
    assign tlast  = last_reg;
    assign tuser  = user_reg;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles UART bytes into HEAD0 HEAD1 LEN payload CHK frames and forwards the payload.
// Optional inter-byte timeout abort is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEAD0          = DEFAULT_HEAD0,
    parameter logic [7:0] HEAD1          = DEFAULT_HEAD1,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_frame_parser_if.slave          s_axis,
    uart_frame_parser_if.master         m_axis,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic [1:0]                  err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_reg;
    logic       run_reg;
    logic [7:0] cnt_reg;
    logic [7:0] acc_reg;
    logic [7:0] hold_reg;
    logic       sticky_reg;
    logic       frame_done_reg;
    logic       frame_err_reg;
    logic [1:0] err_code_reg;

    logic       out_free;
    logic       s_ready;
    logic       xfer;
    logic       chk_bad;
    logic       abort;
    logic       abort_emit;
    logic       load;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_user;

    // Upstream tlast carries no meaning for a UART byte stream.
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis.tlast;

    // run_reg keeps tready low while reset is asserted.
    always_comb begin
        s_ready = 1'b0;
        if (run_reg) begin
            case (state_reg)
                PAY, CHK: s_ready = out_free;
                default:  s_ready = 1'b1;
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign xfer          = s_axis.tvalid && s_ready;
    assign chk_bad       = sticky_reg || s_axis.tuser || (acc_reg != s_axis.tdata);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] idle_cnt_reg;
    logic        emitted_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= 32'd0;
        end else if (state_reg == IDLE || xfer) begin
            idle_cnt_reg <= 32'd0;
        end else if (idle_cnt_reg != TO_LAST) begin
            idle_cnt_reg <= idle_cnt_reg + 32'd1;
        end
    end

    // Tracks whether the downstream has seen an open frame that must be closed on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emitted_reg <= 1'b0;
        end else if (state_reg == LEN && xfer) begin
            emitted_reg <= 1'b0;
        end else if (load && !load_last) begin
            emitted_reg <= 1'b1;
        end
    end

    // Abort waits for a free output register so the closing byte can always be loaded.
    assign abort      = run_reg && (state_reg != IDLE) && (idle_cnt_reg == TO_LAST)
                        && !xfer && out_free;
    assign abort_emit = abort && emitted_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign abort      = 1'b0;
    assign abort_emit = 1'b0;
`endif

    always_comb begin
        load      = 1'b0;
        load_data = s_axis.tdata;
        load_last = 1'b0;
        load_user = 1'b0;
        if (abort) begin
            load      = abort_emit;
            load_data = 8'h00;
            load_last = 1'b1;
            load_user = 1'b1;
        end else if (xfer && state_reg == PAY && cnt_reg != 8'd1) begin
            load = 1'b1;
        end else if (xfer && state_reg == CHK) begin
            load      = 1'b1;
            load_data = hold_reg;
            load_last = 1'b1;
            load_user = chk_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            run_reg        <= 1'b0;
            cnt_reg        <= 8'd0;
            acc_reg        <= 8'd0;
            hold_reg       <= 8'd0;
            sticky_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
        end else begin
            run_reg        <= 1'b1;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (abort) begin
                state_reg     <= IDLE;
                frame_err_reg <= 1'b1;
                err_code_reg  <= ERR_LEN;
            end else if (xfer) begin
                case (state_reg)
                    IDLE: begin
                        if (!s_axis.tuser && s_axis.tdata == HEAD0) state_reg <= H1;
                    end
                    H1: begin
                        if (s_axis.tuser)                state_reg <= IDLE;
                        else if (s_axis.tdata == HEAD1)  state_reg <= LEN;
                        else if (s_axis.tdata == HEAD0)  state_reg <= H1;
                        else                             state_reg <= IDLE;
                    end
                    LEN: begin
                        if (s_axis.tdata == 8'd0 || s_axis.tdata > MAX_LEN_B) begin
                            state_reg     <= IDLE;
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LEN;
                        end else begin
                            cnt_reg    <= s_axis.tdata;
                            acc_reg    <= s_axis.tdata;
                            sticky_reg <= s_axis.tuser;
                            state_reg  <= PAY;
                        end
                    end
                    PAY: begin
                        acc_reg    <= acc_reg ^ s_axis.tdata;
                        sticky_reg <= sticky_reg | s_axis.tuser;
                        cnt_reg    <= cnt_reg - 8'd1;
                        // The final byte waits for CHK so its tuser can carry the verdict.
                        if (cnt_reg == 8'd1) begin
                            hold_reg  <= s_axis.tdata;
                            state_reg <= CHK;
                        end
                    end
                    CHK: begin
                        frame_done_reg <= 1'b1;
                        frame_err_reg  <= chk_bad;
                        if (sticky_reg || s_axis.tuser)     err_code_reg <= ERR_PAR;
                        else if (acc_reg != s_axis.tdata)   err_code_reg <= ERR_CHK;
                        else                                err_code_reg <= ERR_NONE;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    axis_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .load_user (load_user),
        .tready    (m_axis.tready),
        .tdata     (m_axis.tdata),
        .tvalid    (m_axis.tvalid),
        .tlast     (m_axis.tlast),
        .tuser     (m_axis.tuser),
        .free      (out_free)
    );

    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed scoreboard bench for uart_frame_parser: frames, errors, resync, backpressure, reset.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_frame_parser_if s_if ();
    uart_frame_parser_if m_if ();

    uart_frame_parser #(.MAX_LEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axis     (s_if.slave),
        .m_axis     (m_if.master),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } out_t;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
    } st_t;

    out_t out_q[$];
    st_t  st_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_en = 1'b0;
    bit   saw_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input logic [7:0] d, input logic l, input logic u);
        out_t e;
        e.data = d; e.last = l; e.user = u;
        out_q.push_back(e);
    endtask

    task automatic exp_st(input logic dn, input logic er, input logic [1:0] c);
        st_t e;
        e.done = dn; e.err = er; e.code = c;
        st_q.push_back(e);
    endtask

    task automatic mon_out();
        out_t e;
        bit   prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", 32'(m_if.tvalid), 32'd1);
                chk("stall_data", 32'(m_if.tdata), 32'(prev_data));
            end
            prev_stall = rst_n && m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            if (bp_en && s_if.tvalid && !s_if.tready) saw_stall = 1'b1;
            if (m_if.tvalid && m_if.tready) begin
                checks++;
                assert (out_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out: observed %02h expected none", m_if.tdata);
                end
                if (out_q.size() != 0) begin
                    e = out_q.pop_front();
                    $display("out byte %02h last %0d user %0d (expect %02h/%0d/%0d)",
                             m_if.tdata, m_if.tlast, m_if.tuser, e.data, e.last, e.user);
                    chk("out_data", 32'(m_if.tdata), 32'(e.data));
                    chk("out_last", 32'(m_if.tlast), 32'(e.last));
                    if (e.last) chk("out_user", 32'(m_if.tuser), 32'(e.user));
                end
            end
        end
    endtask

    task automatic mon_st();
        st_t e;
        forever begin
            @(negedge clk);
            if (frame_done || frame_err) begin
                checks++;
                assert (st_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_status: observed done %0d err %0d code %0d expected none",
                           frame_done, frame_err, err_code);
                end
                if (st_q.size() != 0) begin
                    e = st_q.pop_front();
                    $display("status done %0d err %0d code %0d", frame_done, frame_err, err_code);
                    chk("frame_done", 32'(frame_done), 32'(e.done));
                    chk("frame_err", 32'(frame_err), 32'(e.err));
                    chk("err_code", 32'(err_code), 32'(e.code));
                end
            end
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = bp_en ? ~m_if.tready : 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic u);
        int   n = 0;
        logic r;
        bit   ok = 1'b0;
        s_if.tdata  = b;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            r = s_if.tready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
            n++;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL send_timeout: observed no accept of %02h expected accept", b);
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int par_pos);
        for (int i = 0; i < b.size(); i++) send(b[i], (i == par_pos));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((out_q.size() != 0 || st_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (out_q.size() == 0 && st_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: observed %0d/%0d pending expected 0/0", tag, out_q.size(), st_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] f[$];
        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        fork
            mon_out();
            mon_st();
            drive_ready();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_s_tready", 32'(s_if.tready), 32'd1);

        // Good frame.
        exp_out(8'h11, 0, 0); exp_out(8'h22, 0, 0); exp_out(8'h33, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_bytes(f, -1);
        wait_drain("good");

        // Bad checksum.
        exp_out(8'h01, 0, 0); exp_out(8'h02, 1, 1);
        exp_st(1, 1, 2'd1);
        f = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'hFF};
        send_bytes(f, -1);
        wait_drain("badchk");
        chk("err_code_held", 32'(err_code), 32'd1);

        // Parity error on the second payload byte, checksum correct.
        exp_out(8'h10, 0, 0); exp_out(8'h20, 1, 1);
        exp_st(1, 1, 2'd2);
        f = '{8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
        send_bytes(f, 4);
        wait_drain("parity");

        // Length zero, then length above the limit, then a good frame.
        exp_st(0, 1, 2'd3);
        f = '{8'h55, 8'hAA, 8'h00};
        send_bytes(f, -1);
        wait_drain("len0");
        exp_st(0, 1, 2'd3);
        f = '{8'h55, 8'hAA, 8'h41};
        send_bytes(f, -1);
        wait_drain("len65");
        exp_out(8'h5A, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h55, 8'hAA, 8'h01, 8'h5A, 8'h5B};
        send_bytes(f, -1);
        wait_drain("after_len");

        // Resync through garbage and a repeated HEAD0.
        exp_out(8'h7E, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_bytes(f, -1);
        wait_drain("resync");

        // Backpressure: downstream ready toggles every cycle.
        bp_en = 1'b1;
        exp_out(8'h7E, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_bytes(f, -1);
        exp_out(8'h01, 0, 0); exp_out(8'h02, 0, 0); exp_out(8'h03, 0, 0);
        exp_out(8'h04, 0, 0); exp_out(8'h05, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04};
        send_bytes(f, -1);
        wait_drain("backpressure");
        chk("bp_s_tready_dropped", 32'(saw_stall), 32'd1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Leave err_code nonzero, then reset in the middle of a frame.
        exp_st(0, 1, 2'd3);
        f = '{8'h55, 8'hAA, 8'h00};
        send_bytes(f, -1);
        wait_drain("len0_again");
        f = '{8'h55, 8'hAA, 8'h04, 8'h01};
        send_bytes(f, -1);
        #2;
        chk("pre_rst_m_tvalid", 32'(m_if.tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("mid_rst_m_tdata", 32'(m_if.tdata), 32'd0);
        chk("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("mid_rst_err_code", 32'(err_code), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_out(8'hA1, 0, 0); exp_out(8'hB2, 1, 0);
        exp_st(1, 0, 2'd0);
        f = '{8'h55, 8'hAA, 8'h02, 8'hA1, 8'hB2, 8'h11};
        send_bytes(f, -1);
        wait_drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
